// File: rtl/mac_pkg.sv
// Shared types and helpers for the tx_mac user-side AXIS arbiter.
package mac_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_FLUSH
  } arb_state_t;

  localparam int MAX_PORTS = 8;

  function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after i_last_grant,
// wrapping modulo N. Output is one-hot, zero when nothing requests.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_grant,
  output logic [N-1:0]  o_grant
);

  localparam int IW1 = IW + 1;

  logic [IW1-1:0] w_idx;
  logic           w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = {1'b0, i_last_grant} + IW1'(k);
      if (w_idx >= IW1'(N)) w_idx = w_idx - IW1'(N);
      if (!w_found && i_req[w_idx[IW-1:0]]) begin
        o_grant[w_idx[IW-1:0]] = 1'b1;
        w_found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_axis_arbiter.sv
// Packet-level round-robin arbiter feeding the single tx_mac user AXIS input.
// Grants whole frames; a mid-frame tvalid gap aborts and flushes the remainder.
module tx_axis_arbiter
  import mac_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [N_PORTS-1:0]           s_axis_tvalid,
  input  logic [N_PORTS-1:0]           s_axis_tlast,
  output logic [N_PORTS-1:0]           s_axis_tready,
  input  logic [N_PORTS-1:0]           i_port_enable,
  output logic [DATA_WIDTH-1:0]        m00_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m00_axis_tkeep,
  output logic                         m00_axis_tvalid,
  output logic                         m00_axis_tlast,
  input  logic                         m00_axis_tready,
  output logic [N_PORTS-1:0]           o_grant,
  output logic                         o_abort
);

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [N_PORTS-1:0]  r_grant;
  logic [IW-1:0]       r_grant_idx;
  logic [IW-1:0]       r_last_grant;
  logic                r_frame_started;
  logic                r_abort;

  logic [N_PORTS-1:0]  w_req;
  logic [N_PORTS-1:0]  w_rr_grant;
  logic [DATA_WIDTH-1:0] w_tdata_arr [N_PORTS];
  logic [KEEP_WIDTH-1:0] w_tkeep_arr [N_PORTS];
  logic                w_sel_tvalid;
  logic                w_sel_tlast;
  logic                w_accept;
  logic                w_gap;
  logic                w_done;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
    assign w_tdata_arr[p] = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
    assign w_tkeep_arr[p] = s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
  end

  assign w_req          = s_axis_tvalid & i_port_enable;
  assign w_sel_tvalid   = s_axis_tvalid[r_grant_idx];
  assign w_sel_tlast    = s_axis_tlast[r_grant_idx];
  assign m00_axis_tdata = w_tdata_arr[r_grant_idx];
  assign m00_axis_tkeep = w_tkeep_arr[r_grant_idx];
  assign o_grant        = r_grant;
  assign o_abort        = r_abort;

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_rr_grant)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ARB_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    s_axis_tready   = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    w_accept        = 1'b0;
    w_gap           = 1'b0;
    w_done          = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (|w_req) w_state_next = ARB_GRANT;
      end
      ARB_GRANT: begin
        s_axis_tready   = r_grant & {N_PORTS{m00_axis_tready}};
        m00_axis_tvalid = w_sel_tvalid;
        m00_axis_tlast  = w_sel_tlast;
        w_accept        = w_sel_tvalid & m00_axis_tready;
        // A gap before the first beat only holds the grant
        w_gap           = r_frame_started & ~w_sel_tvalid & m00_axis_tready;
        if (w_accept && w_sel_tlast) begin
          w_done       = 1'b1;
          w_state_next = ARB_IDLE;
        end else if (w_gap) begin
          w_state_next = ARB_FLUSH;
        end
      end
      ARB_FLUSH: begin
        s_axis_tready = r_grant;
        if (w_sel_tvalid && w_sel_tlast) begin
          w_done       = 1'b1;
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_grant         <= '0;
      r_grant_idx     <= '0;
      r_last_grant    <= IW'(N_PORTS - 1);
      r_frame_started <= 1'b0;
      r_abort         <= 1'b0;
    end else begin
      r_abort <= w_gap;
      if (r_state == ARB_IDLE && |w_req) begin
        r_grant     <= w_rr_grant;
        r_grant_idx <= IW'(onehot_to_idx(MAX_PORTS'(w_rr_grant)));
      end
      if (w_accept) r_frame_started <= 1'b1;
      if (w_done) begin
        r_last_grant    <= r_grant_idx;
        r_grant         <= '0;
        r_frame_started <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Randomized bench for tx_axis_arbiter against a frame-level round-robin model.
module tb_tx_axis_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP*DW-1:0]     s_axis_tdata;
  logic [NP*KW-1:0]     s_axis_tkeep;
  logic [NP-1:0]        s_axis_tvalid;
  logic [NP-1:0]        s_axis_tlast;
  logic [NP-1:0]        s_axis_tready;
  logic [NP-1:0]        i_port_enable;
  logic [DW-1:0]        m00_axis_tdata;
  logic [KW-1:0]        m00_axis_tkeep;
  logic                 m00_axis_tvalid;
  logic                 m00_axis_tlast;
  logic                 m00_axis_tready;
  logic [NP-1:0]        o_grant;
  logic                 o_abort;

  always #5 clk = ~clk;

  tx_axis_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .i_port_enable   (i_port_enable),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tkeep  (m00_axis_tkeep),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tlast  (m00_axis_tlast),
    .m00_axis_tready (m00_axis_tready),
    .o_grant         (o_grant),
    .o_abort         (o_abort)
  );

  typedef struct {
    int len;
    int gap_at;
    int gap_len;
    int id;
  } frame_t;

  frame_t      fq [NP][$];
  int          beat [NP];
  int          gap_left [NP];
  bit          gap_done [NP];
  int          delivered [NP];
  int          grant_log [$];
  int          aborts_seen;
  int          m_owner, m_last, m_sent;
  bit          m_discard, m_abort_exp;
  int          cyc, prev_end, last_gap, next_id;
  int          checks, errors;
  logic [NP-1:0] en_val;
  int          rdy_mode;
  bit          hook_en0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] beat_data(int p, int id, int b);
    return {8'(p), 8'hA5, 16'(id), 32'(b * 40503 + 1)};
  endfunction

  function automatic logic [7:0] beat_keep(int id, int b, int len);
    logic [7:0] k;
    k = 8'hFF;
    if (b == len - 1) k = k >> (id % 8);
    return k;
  endfunction

  task automatic add_frame(input int p, input int len, input int gap_at = -1, input int gap_len = 0);
    frame_t f;
    f.len = len; f.gap_at = gap_at; f.gap_len = gap_len; f.id = next_id;
    next_id++;
    fq[p].push_back(f);
  endtask

  function automatic bit all_done();
    if (m_owner >= 0) return 1'b0;
    for (int p = 0; p < NP; p++)
      if (en_val[p] && fq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      fq[p].delete(); beat[p] = 0; gap_left[p] = 0; gap_done[p] = 1'b0;
    end
    m_owner = -1; m_last = NP - 1; m_sent = 0; m_discard = 1'b0; m_abort_exp = 1'b0;
    prev_end = -1;
  endtask

  // One clock: drive at negedge, settle, compare against the frame-level model.
  task automatic step();
    logic [NP-1:0] tv, tl, req, exp_rdy, eg;
    int o, pick, pp;
    @(negedge clk);
    cyc++;
    for (int p = 0; p < NP; p++) begin
      tv[p] = (fq[p].size() > 0) && (gap_left[p] == 0);
      tl[p] = 1'b0;
      s_axis_tdata[p*DW +: DW] = '0;
      s_axis_tkeep[p*KW +: KW] = '0;
      if (tv[p]) begin
        tl[p] = (beat[p] == fq[p][0].len - 1);
        s_axis_tdata[p*DW +: DW] = beat_data(p, fq[p][0].id, beat[p]);
        s_axis_tkeep[p*KW +: KW] = beat_keep(fq[p][0].id, beat[p], fq[p][0].len);
      end
    end
    s_axis_tvalid = tv;
    s_axis_tlast  = tl;
    case (rdy_mode)
      1:       m00_axis_tready = (cyc % 2 == 0);
      2:       m00_axis_tready = ($urandom_range(0, 9) < 7);
      default: m00_axis_tready = 1'b1;
    endcase
    i_port_enable = en_val;
    #1;
    req = tv & en_val;
    check("abort", o_abort, m_abort_exp);
    if (o_abort) aborts_seen++;
    m_abort_exp = 1'b0;
    if (m_owner < 0) begin
      check("grant_idle", o_grant, 0);
      check("ready_idle", s_axis_tready, 0);
      check("valid_idle", m00_axis_tvalid, 0);
      pick = -1;
      for (int k = 1; k <= NP; k++) begin
        pp = (m_last + k) % NP;
        if (pick < 0 && req[pp]) pick = pp;
      end
      if (pick >= 0) begin
        m_owner = pick; m_sent = 0; m_discard = 1'b0;
        grant_log.push_back(pick);
      end
    end else begin
      o = m_owner;
      eg = '0; eg[o] = 1'b1;
      exp_rdy = '0; exp_rdy[o] = m_discard ? 1'b1 : m00_axis_tready;
      check("grant", o_grant, eg);
      check("ready", s_axis_tready, exp_rdy);
      if (m_discard) begin
        check("valid_flush", m00_axis_tvalid, 0);
        if (tv[o] && tl[o]) begin
          m_last = o; m_owner = -1; prev_end = cyc;
        end
      end else begin
        check("valid", m00_axis_tvalid, tv[o]);
        if (tv[o])
          check("beat", {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata},
                {tl[o], beat_keep(fq[o][0].id, beat[o], fq[o][0].len), beat_data(o, fq[o][0].id, beat[o])});
        if (tv[o] && m00_axis_tready) begin
          delivered[o]++;
          if (m_sent == 0 && prev_end >= 0) last_gap = cyc - prev_end;
          m_sent++;
          if (tl[o]) begin
            m_last = o; m_owner = -1; prev_end = cyc;
          end else if (hook_en0 && o == 0 && m_sent == 1 && en_val[0]) begin
            en_val[0] = 1'b0;
          end
        end else if (m_sent > 0 && !tv[o] && m00_axis_tready) begin
          m_discard = 1'b1; m_abort_exp = 1'b1;
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (gap_left[p] > 0) gap_left[p]--;
      else if (tv[p] && s_axis_tready[p]) begin
        beat[p]++;
        if (beat[p] == fq[p][0].len) begin
          void'(fq[p].pop_front()); beat[p] = 0; gap_done[p] = 1'b0;
        end else if (beat[p] == fq[p][0].gap_at && !gap_done[p]) begin
          gap_left[p] = fq[p][0].gap_len; gap_done[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, all_done(), 1);
    step();
    step();
  endtask

  int d [NP];
  int a0, tot0, sum_len, len0, n1, n;

  initial begin
    checks = 0; errors = 0; cyc = 0; next_id = 0; aborts_seen = 0; last_gap = -1;
    rdy_mode = 0; hook_en0 = 1'b0; en_val = '1;
    for (int p = 0; p < NP; p++) delivered[p] = 0;
    model_reset();
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    i_port_enable = '1; m00_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", o_grant, 0);
    check("rst_ready", s_axis_tready, 0);
    check("rst_valid", m00_axis_tvalid, 0);
    check("rst_abort", o_abort, 0);
    @(negedge clk);
    rst = 1'b0;
    step(); step();

    // All four ports with three frames each
    grant_log.delete();
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < NP; p++) add_frame(p, $urandom_range(1, 6));
    run("s2", 400);
    check("s2_count", grant_log.size(), 12);
    for (int i = 0; i < 12 && i < grant_log.size(); i++) check("s2_order", grant_log[i], i % NP);

    // Ports 0 and 2, 9 beats each
    grant_log.delete();
    for (int p = 0; p < NP; p++) d[p] = delivered[p];
    add_frame(0, 9); add_frame(2, 9);
    run("s1", 200);
    check("s1_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("s1_first", grant_log[0], 0);
      check("s1_second", grant_log[1], 2);
    end
    check("s1_gap", last_gap, 2);
    check("s1_beats0", delivered[0] - d[0], 9);
    check("s1_beats2", delivered[2] - d[2], 9);

    // Toggling downstream ready on port 1
    rdy_mode = 1; a0 = aborts_seen; d[1] = delivered[1];
    add_frame(1, 8);
    run("s3", 200);
    rdy_mode = 0;
    check("s3_no_abort", aborts_seen - a0, 0);
    check("s3_beats", delivered[1] - d[1], 8);

    // Port 3 gap after beat 4 of 10, port 0 waiting
    grant_log.delete(); a0 = aborts_seen; d[3] = delivered[3]; d[0] = delivered[0];
    add_frame(3, 10, 4, 2); add_frame(0, 5);
    run("s4", 200);
    check("s4_aborts", aborts_seen - a0, 1);
    check("s4_beats3", delivered[3] - d[3], 4);
    check("s4_beats0", delivered[0] - d[0], 5);
    check("s4_order", grant_log.size() == 2 && grant_log[0] == 3 && grant_log[1] == 0, 1);

    // Port 1 disabled; port 0 disabled mid-frame
    grant_log.delete(); en_val = 4'b1101; hook_en0 = 1'b1;
    for (int p = 0; p < NP; p++) d[p] = delivered[p];
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NP; p++) add_frame(p, $urandom_range(3, 6));
    len0 = fq[0][0].len;
    sum_len = fq[2][0].len + fq[2][1].len;
    run("s5", 400);
    hook_en0 = 1'b0;
    n1 = 0;
    foreach (grant_log[i]) if (grant_log[i] == 1) n1++;
    check("s5_port1_grants", n1, 0);
    check("s5_beats1", delivered[1] - d[1], 0);
    check("s5_beats0", delivered[0] - d[0], len0);
    check("s5_beats2", delivered[2] - d[2], sum_len);
    fq[0].delete(); fq[1].delete();
    en_val = '1;

    // Random traffic with random downstream ready
    rdy_mode = 2; sum_len = 0; tot0 = 0;
    for (int p = 0; p < NP; p++) tot0 += delivered[p];
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(1, 8);
      sum_len += n;
      add_frame($urandom_range(0, NP - 1), n);
    end
    run("rand", 2000);
    rdy_mode = 0;
    n = 0;
    for (int p = 0; p < NP; p++) n += delivered[p];
    check("rand_beats", n - tot0, sum_len);

    // Reset during beat 3
    add_frame(1, 8); add_frame(2, 8);
    n = 0;
    while (!(m_owner >= 0 && m_sent == 2) && n < 100) begin
      step();
      n++;
    end
    check("s6_reach", m_owner >= 0 && m_sent == 2, 1);
    #2 rst = 1'b1;
    #1;
    check("s6_ready", s_axis_tready, 0);
    check("s6_valid", m00_axis_tvalid, 0);
    check("s6_grant", o_grant, 0);
    model_reset();
    s_axis_tvalid = '0; s_axis_tlast = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    add_frame(3, 4); add_frame(1, 4); add_frame(0, 4); add_frame(2, 3);
    run("s6", 200);
    check("s6_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("s6_order", grant_log[i], i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", checks);
    $fatal(1, "watchdog");
  end

endmodule
